counter_checker: RTL



---
 rtl/counter_chk_pkg.sv | 15 +
 rtl/counter_checker_if.sv | 14 +
 rtl/counter_chk_dly.sv | 33 +++
 rtl/counter_checker.sv | 106 ++++++++++
 4 files changed

// File: rtl/counter_chk_pkg.sv
// counter_chk_pkg: shared constants, checker states and the mod-12 step function
package counter_chk_pkg;

    localparam int MOD = 12;
    localparam int DW  = 4;

    typedef enum logic [1:0] {UNSYNC, SYNC, HALT} chk_state_e;

    // next value of a mod-MOD up/down counter; wraps MOD-1 <-> 0
    function automatic logic [DW-1:0] mod_step(input logic [DW-1:0] val, input logic mode);
        if (mode) return (val == DW'(MOD - 1)) ? '0 : val + 1'b1;
        return (val == '0) ? DW'(MOD - 1) : val - 1'b1;
    endfunction

endpackage

// File: rtl/counter_checker_if.sv
// counter_checker_if: counter stimulus and count output as seen on the counter's ports
interface counter_checker_if;
    import counter_chk_pkg::*;

    logic          mon_rst;
    logic          mon_mode;
    logic          mon_load;
    logic [DW-1:0] mon_data_in;
    logic [DW-1:0] mon_data_out;

    modport master (output mon_rst, mon_mode, mon_load, mon_data_in, mon_data_out);
    modport slave  (input  mon_rst, mon_mode, mon_load, mon_data_in, mon_data_out);

endinterface

// File: rtl/counter_chk_dly.sv
// counter_chk_dly: (value, valid) shift line aligning predictions with the counter's output latency
module counter_chk_dly #(
    parameter int W     = 4,
    parameter int DEPTH = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] val_i,
    input  logic         vld_i,
    output logic [W-1:0] val_o,
    output logic         vld_o
);

    if (DEPTH == 0) begin : g_thru
        logic unused_clk;
        assign unused_clk = clk ^ rst_n;
        assign val_o      = val_i;
        assign vld_o      = vld_i;
    end else begin : g_pipe
        logic [W:0] pipe_q [DEPTH];
        // one stage per edge; reset drops every in-flight entry
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                pipe_q <= '{default: '0};
            end else begin
                pipe_q[0] <= {vld_i, val_i};
                for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
            end
        end
        assign {vld_o, val_o} = pipe_q[DEPTH-1];
    end

endmodule

// File: rtl/counter_checker.sv
// counter_checker: passive predictor/comparator for a loadable up/down mod-12 counter
module counter_checker
    import counter_chk_pkg::*;
#(
    parameter int LATENCY     = 1,
    parameter int CNT_W       = 16,
    parameter bit STOP_ON_ERR = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en_i,
    input  logic                clr_i,
    counter_checker_if.slave    mon,
    output logic                synced_o,
    output logic [DW-1:0]       exp_out_o,
    output logic                err_o,
    output logic                err_sticky_o,
    output logic                illegal_load_o,
    output logic [CNT_W-1:0]    chk_cnt_o,
    output logic [CNT_W-1:0]    err_cnt_o
);

    logic [DW-1:0]    pred_q, pred_d;
    logic             vld_q, vld_d;
    logic             ill_q, ill_d;
    logic             err_q;
    logic             sticky_q, sticky_d;
    logic [CNT_W-1:0] chk_q, chk_d;
    logic [CNT_W-1:0] errc_q, errc_d;
    chk_state_e       state_q, state_d;
    logic [DW-1:0]    tail_val;
    logic             tail_vld;
    logic             legal, cmp, mis;

    // prediction of the counter's next value; an out-of-range load invalidates it
    always_comb begin
        legal  = mon.mon_data_in < DW'(MOD);
        pred_d = mon.mon_rst  ? '0 :
                 mon.mon_load ? (legal ? mon.mon_data_in : pred_q) :
                 mod_step(pred_q, mon.mon_mode);
        vld_d  = mon.mon_rst | (mon.mon_load ? legal : vld_q);
        ill_d  = !mon.mon_rst && mon.mon_load && !legal;
    end

    counter_chk_dly #(.W(DW), .DEPTH(LATENCY - 1)) u_dly (
        .clk   (clk),
        .rst_n (rst_n),
        .val_i (pred_q),
        .vld_i (vld_q),
        .val_o (tail_val),
        .vld_o (tail_vld)
    );

    // compare only while locked; clr overrides counters and sticky flag but not the pulse
    always_comb begin
        cmp      = en_i && tail_vld && state_q == SYNC;
        mis      = cmp && mon.mon_data_out != tail_val;
        chk_d    = clr_i ? '0 : (cmp && ~&chk_q) ? chk_q + 1'b1 : chk_q;
        errc_d   = clr_i ? '0 : (mis && ~&errc_q) ? errc_q + 1'b1 : errc_q;
        sticky_d = clr_i ? 1'b0 : (mis ? 1'b1 : sticky_q);
    end

    // lock onto a valid prediction, drop out on an illegal load, park on error if asked
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            UNSYNC:  if (tail_vld) state_d = SYNC;
            SYNC:    if (!tail_vld) state_d = UNSYNC;
                     else if (mis && STOP_ON_ERR) state_d = HALT;
            HALT:    if (clr_i) state_d = UNSYNC;
            default: state_d = UNSYNC;
        endcase
    end

    // all checker state; rst_n discards predictions in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pred_q   <= '0;
            vld_q    <= 1'b0;
            ill_q    <= 1'b0;
            state_q  <= UNSYNC;
            err_q    <= 1'b0;
            sticky_q <= 1'b0;
            chk_q    <= '0;
            errc_q   <= '0;
        end else begin
            pred_q   <= pred_d;
            vld_q    <= vld_d;
            ill_q    <= ill_d;
            state_q  <= state_d;
            err_q    <= mis;
            sticky_q <= sticky_d;
            chk_q    <= chk_d;
            errc_q   <= errc_d;
        end
    end

    assign synced_o       = state_q == SYNC;
    assign exp_out_o      = tail_val;
    assign err_o          = err_q;
    assign err_sticky_o   = sticky_q;
    assign illegal_load_o = ill_q;
    assign chk_cnt_o      = chk_q;
    assign err_cnt_o      = errc_q;

endmodule
